mult_div_unit: RTL and testbench



---
 rtl/mult_div_pkg.sv | 22 ++
 rtl/mult_div_abs.sv | 21 ++
 rtl/mult_div_unit.sv | 196 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
`default_nettype none
// mult_div_pkg: op encodings, sequencer states and sizing shared with the control unit.
// Rev 1.0
package mult_div_pkg;

  localparam int MD_WIDTH      = 32;
  localparam int MD_ITERATIONS = MD_WIDTH;

  localparam logic [1:0] MD_OP_NONE = 2'b00;
  localparam logic [1:0] MD_OP_MULT = 2'b01;
  localparam logic [1:0] MD_OP_DIV  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MULT_RUN = 3'd1,
    ST_DIV_RUN  = 3'd2,
    ST_DIV_FIX  = 3'd3,
    ST_DONE     = 3'd4
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/mult_div_abs.sv
`default_nettype none
// mult_div_abs: two's-complement sign/magnitude extract plus conditional negate.
// Rev 1.0
module mult_div_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_extract,
  input  logic             i_negate,
  output logic [WIDTH-1:0] o_res,
  output logic             o_sign
);

  logic w_flip;

  assign o_sign = i_extract & i_val[WIDTH-1];
  assign w_flip = o_sign ^ i_negate;
  assign o_res  = w_flip ? (~i_val + 1'b1) : i_val;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// mult_div_unit: multicycle shift-add multiply / restoring divide for HI/LO.
// Optional unsigned operation: define MULT_DIV_UNSIGNED_EN. Rev 1.0
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             signedn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e          r_state;
  md_state_e          w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_sa;
  logic               r_sb;
  logic               r_bzero;
  logic               r_div_zero;

  logic               w_signed;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_sa;
  logic               w_sb;

`ifdef MULT_DIV_UNSIGNED_EN
  assign w_signed = signedn;
`else
  logic w_unused_signedn;
  assign w_unused_signedn = signedn;
  assign w_signed         = 1'b1;
`endif

  assign w_accept = (r_state == ST_IDLE) && start &&
                    ((op == MD_OP_MULT) || (op == MD_OP_DIV));
  assign w_last   = (r_cnt == LAST);

  mult_div_abs #(.WIDTH(WIDTH)) u_abs_a (
    .i_val(a), .i_extract(w_signed), .i_negate(1'b0), .o_res(w_mag_a), .o_sign(w_sa)
  );
  mult_div_abs #(.WIDTH(WIDTH)) u_abs_b (
    .i_val(b), .i_extract(w_signed), .i_negate(1'b0), .o_res(w_mag_b), .o_sign(w_sb)
  );

  // Multiply: r_acc = {partial, multiplier}; add multiplicand on the low bit, shift right.
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mult_next;
  assign w_msum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                       (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mult_next = {w_msum, r_acc[WIDTH-1:1]};

  // Divide: r_acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor.
  logic [WIDTH:0]     w_rshift;
  logic [WIDTH-1:0]   w_sub;
  logic               w_take;
  logic [WIDTH-1:0]   w_new_rem;
  logic [2*WIDTH-1:0] w_div_next;
  assign w_rshift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_take     = (w_rshift >= {1'b0, r_opnd});
  assign w_sub      = w_rshift[WIDTH-1:0] - r_opnd;
  assign w_new_rem  = w_take ? w_sub : w_rshift[WIDTH-1:0];
  assign w_div_next = {w_new_rem, r_acc[WIDTH-2:0], w_take};

  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [2:0]         w_unused_fix_signs;

  mult_div_abs #(.WIDTH(2*WIDTH)) u_fix_prod (
    .i_val(w_mult_next), .i_extract(1'b0), .i_negate(r_sa ^ r_sb),
    .o_res(w_prod_fix), .o_sign(w_unused_fix_signs[0])
  );
  mult_div_abs #(.WIDTH(WIDTH)) u_fix_quo (
    .i_val(r_acc[WIDTH-1:0]), .i_extract(1'b0), .i_negate(r_sa ^ r_sb),
    .o_res(w_quo_fix), .o_sign(w_unused_fix_signs[1])
  );
  mult_div_abs #(.WIDTH(WIDTH)) u_fix_rem (
    .i_val(r_acc[2*WIDTH-1:WIDTH]), .i_extract(1'b0), .i_negate(r_sa),
    .o_res(w_rem_fix), .o_sign(w_unused_fix_signs[2])
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (op == MD_OP_MULT) ? ST_MULT_RUN : ST_DIV_RUN;
        end
      end
      ST_MULT_RUN: begin
        if (w_last) w_next = ST_DONE;
      end
      ST_DIV_RUN: begin
        if (r_bzero)     w_next = ST_DONE;
        else if (w_last) w_next = ST_DIV_FIX;
      end
      ST_DIV_FIX: w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != ST_IDLE);
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_bzero    <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sa       <= w_sa;
            r_sb       <= w_sb;
            r_div_zero <= 1'b0;
            r_cnt      <= '0;
            r_bzero    <= (op == MD_OP_DIV) && (b == '0);
            if (op == MD_OP_MULT) begin
              r_opnd <= w_mag_a;
              r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
            end else begin
              r_opnd <= w_mag_b;
              r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
            end
          end
        end
        ST_MULT_RUN: begin
          r_acc <= w_mult_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        ST_DIV_RUN: begin
          if (r_bzero) begin
            r_div_zero <= 1'b1;
          end else begin
            r_acc <= w_div_next;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DIV_FIX: begin
          r_lo <= w_quo_fix;
          r_hi <= w_rem_fix;
        end
        default: begin
        end
      endcase
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// tb_mult_div_unit: directed + random MULT/DIV checked against an arithmetic reference model.
// Rev 1.0
module tb_mult_div_unit;
  import mult_div_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic        signedn;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;

  mult_div_unit #(.WIDTH(MD_WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .signedn(signedn),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit integer arithmetic; SV division truncates toward zero.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic sgn);
    longint sx, sy, p, q, r;
    sx = sgn ? longint'($signed(x)) : longint'({32'b0, x});
    sy = sgn ? longint'($signed(y)) : longint'({32'b0, y});
    if (o == MD_OP_MULT) begin
      p    = sx * sy;
      m_hi = p[63:32];
      m_lo = p[31:0];
      m_dz = 1'b0;
    end else if (y == 32'd0) begin
      m_dz = 1'b1;
    end else begin
      q    = sx / sy;
      r    = sx % sy;
      m_lo = q[31:0];
      m_hi = r[31:0];
      m_dz = 1'b0;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic sgn, input int inject);
    int lat, first, ndone;
    logic busy_ok;
    @(negedge clk);
    op = o; a = x; b = y; signedn = sgn; start = 1'b1;
`ifdef MULT_DIV_UNSIGNED_EN
    model(o, x, y, sgn);
`else
    model(o, x, y, 1'b1);
`endif
    lat = (o == MD_OP_MULT) ? 32 : ((y == 32'd0) ? 1 : 33);
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; signedn = $urandom_range(0, 1);
    op = 2'($urandom_range(0, 3));
    first = -1; ndone = 0; busy_ok = 1'b1;
    for (int i = 0; i <= lat + 1; i++) begin
      @(negedge clk);
      start = (i == inject);
      if (i == inject) op = MD_OP_DIV;
      if (done) begin
        ndone++;
        if (first < 0) first = i;
      end
      if (busy !== (i <= lat)) busy_ok = 1'b0;
      if (i == lat) begin
        check({tag, ".hi"}, 64'(hi), 64'(m_hi));
        check({tag, ".lo"}, 64'(lo), 64'(m_lo));
        check({tag, ".div_zero"}, 64'(div_zero), 64'(m_dz));
      end
      if (i == lat + 1) begin
        check({tag, ".hold"}, {hi, lo}, {m_hi, m_lo});
      end
    end
    start = 1'b0;
    check({tag, ".done_at"}, 64'(first), 64'(lat));
    check({tag, ".done_cnt"}, 64'(ndone), 64'(1));
    check({tag, ".busy_window"}, 64'(busy_ok), 64'(1));
  endtask

  logic [1:0]  r_o;
  logic [31:0] r_x, r_y;
  logic        r_s;

  initial begin
    reset = 1'b1; start = 1'b0; op = MD_OP_NONE; signedn = 1'b1; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.outs", {31'b0, div_zero, hi, lo}, 64'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle.busy", 64'(busy), 64'(0));

    run("mul_7_m3",   MD_OP_MULT, 32'd7,          32'hFFFF_FFFD, 1'b1, -1);
    run("div_100_7",  MD_OP_DIV,  32'd100,        32'd7,         1'b1, -1);
    run("div_m7_2",   MD_OP_DIV,  32'hFFFF_FFF9,  32'd2,         1'b1, -1);
    run("div_by_0",   MD_OP_DIV,  32'd5,          32'd0,         1'b1, -1);
    run("mul_clr_dz", MD_OP_MULT, 32'h1234_5678,  32'h0000_0010, 1'b1, -1);
    run("div_ovf",    MD_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 1'b1, -1);
    run("mul_min",    MD_OP_MULT, 32'h8000_0000,  32'h8000_0000, 1'b1, -1);
    run("mul_inject", MD_OP_MULT, 32'h0000_1234,  32'hFFFF_5678, 1'b1, 5);

    @(negedge clk);
    op = 2'b11; start = 1'b1;
    @(posedge clk);
    #1;
    check("op11.busy", 64'(busy), 64'(0));
    op = MD_OP_NONE;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("op00.busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("ign.outs", {31'b0, done, hi}, {31'b0, 1'b0, m_hi});

    for (int k = 0; k < 30; k++) begin
      r_o = $urandom_range(0, 1) ? MD_OP_MULT : MD_OP_DIV;
      r_x = $urandom;
      r_y = $urandom;
      case ($urandom_range(0, 7))
        0: r_y = 32'd0;
        1: r_y = 32'($urandom_range(1, 15));
        2: r_y = -32'($urandom_range(1, 15));
        3: r_x = 32'h8000_0000;
        default: ;
      endcase
`ifdef MULT_DIV_UNSIGNED_EN
      r_s = 1'($urandom_range(0, 1));
`else
      r_s = 1'b1;
`endif
      run($sformatf("rnd%0d", k), r_o, r_x, r_y, r_s, -1);
    end

    @(negedge clk);
    op = MD_OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst.busy", 64'(busy), 64'(0));
    check("midrst.done", 64'(done), 64'(0));
    check("midrst.hilo", {hi, lo}, 64'(0));
    check("midrst.dz", 64'(div_zero), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    run("mul_3_4", MD_OP_MULT, 32'd3, 32'd4, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
